// File: rtl/frame_buffer_scanout.sv
`default_nettype none
//==============================================================================
// Module   : frame_buffer_scanout
// Brief    : Reads a rendered frame linearly out of the CD SRAM and serialises
//            it into a one-pixel-per-beat valid/ready stream.
//            Define SCANOUT_CLEAR_EN to clear each word behind the read.
// Revision : 1.0  initial release
//==============================================================================
module frame_buffer_scanout #(
   parameter int          H_WORDS     = 40,
   parameter int          V_LINES     = 480,
   parameter logic [23:0] CLEAR_COLOR = 24'h0
) (
   input  logic         clk,
   input  logic         srst_n,
   input  logic         start,
   output logic         busy,
   output logic         done,
   output logic [15:0]  address_sram_CD,
   output logic         write_enable_sram_CD,
   output logic [15:0]  write_wordmask_sram_CD,
   input  logic [383:0] Color_RGB_sram,
   output logic [383:0] Color_RGB_clear,
   output logic [335:0] depth_clear,
   output logic         pix_valid,
   input  logic         pix_ready,
   output logic [23:0]  pix_rgb,
   output logic         pix_sof,
   output logic         pix_eol
);

   localparam logic [16:0] C_TOTAL_WORDS = 17'(H_WORDS * V_LINES);
   localparam logic [16:0] C_LAST_WORD   = 17'(H_WORDS * V_LINES - 1);
   localparam logic [16:0] C_LAST_COL    = 17'(H_WORDS - 1);

   localparam logic [1:0] C_IDLE = 2'd0;
   localparam logic [1:0] C_RUN  = 2'd1;
   localparam logic [1:0] C_DONE = 2'd2;

   logic [1:0]   r_state;
   logic [16:0]  r_rd_addr;
   logic         r_inflight;
   logic [15:0]  r_last_addr;
   logic [383:0] r_buf0;
   logic [383:0] r_buf1;
   logic         r_wr_ptr;
   logic         r_rd_ptr;
   logic [1:0]   r_count;
   logic [3:0]   r_pix;
   logic [16:0]  r_head_word;
   logic [16:0]  r_col;

   logic         w_run;
   logic         w_start_accept;
   logic         w_fire;
   logic         w_pop;
   logic         w_last_fire;
   logic         w_capture;
   logic [1:0]   w_occupancy;
   logic         w_rd_issue;
   logic         w_clr_issue;
   logic [15:0]  w_clr_addr;
   logic [15:0]  w_addr;
   logic [383:0] w_head;
   logic [23:0]  w_pix;

   assign w_run          = (r_state == C_RUN);
   assign w_start_accept = (r_state == C_IDLE) && start;
   assign busy           = w_run;
   assign done           = (r_state == C_DONE);

   assign pix_valid   = w_run && (r_count != 2'd0);
   assign w_fire      = pix_valid && pix_ready;
   assign w_pop       = w_fire && (r_pix == 4'd15);
   assign w_last_fire = w_pop && (r_head_word == C_LAST_WORD);

   // Read data arrives exactly one cycle after the read, so a read in flight
   // is a capture in the current cycle.
   assign w_capture   = r_inflight;
   assign w_occupancy = r_count + {1'b0, r_inflight};
   assign w_rd_issue  = w_run && !w_clr_issue &&
                        (r_rd_addr < C_TOTAL_WORDS) && (w_occupancy < 2'd2);

   //---------------------------------------------------------------------------
   // Control FSM
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         r_state <= C_IDLE;
      end else begin
         case (r_state)
            C_IDLE:  if (start) r_state <= C_RUN;
            // A word's clear write always issues the cycle after capture, well
            // before its 16th pixel can be accepted, so no clear is pending here.
            C_RUN:   if (w_last_fire) r_state <= C_DONE;
            C_DONE:  r_state <= C_IDLE;
            default: r_state <= C_IDLE;
         endcase
      end
   end

   //---------------------------------------------------------------------------
   // Read issue and word-buffer bookkeeping
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         r_rd_addr  <= 17'd0;
         r_inflight <= 1'b0;
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_count    <= 2'd0;
      end else if (w_start_accept) begin
         r_rd_addr  <= 17'd0;
         r_inflight <= 1'b0;
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_count    <= 2'd0;
      end else begin
         r_inflight <= w_rd_issue;
         if (w_rd_issue) r_rd_addr <= r_rd_addr + 17'd1;
         if (w_capture)  r_wr_ptr  <= ~r_wr_ptr;
         if (w_pop)      r_rd_ptr  <= ~r_rd_ptr;
         case ({w_capture, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_capture && !r_wr_ptr) r_buf0 <= Color_RGB_sram;
      if (w_capture &&  r_wr_ptr) r_buf1 <= Color_RGB_sram;
   end

   //---------------------------------------------------------------------------
   // Pixel serialisation position
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         r_pix       <= 4'd0;
         r_head_word <= 17'd0;
         r_col       <= 17'd0;
      end else if (w_start_accept) begin
         r_pix       <= 4'd0;
         r_head_word <= 17'd0;
         r_col       <= 17'd0;
      end else begin
         if (w_fire) r_pix <= r_pix + 4'd1;
         if (w_pop) begin
            r_head_word <= r_head_word + 17'd1;
            r_col       <= (r_col == C_LAST_COL) ? 17'd0 : r_col + 17'd1;
         end
      end
   end

   assign w_head = r_rd_ptr ? r_buf1 : r_buf0;

   always_comb begin
      w_pix = 24'h0;
      for (int i = 0; i < 16; i++) begin
         if (r_pix == 4'(i)) w_pix = w_head[24*i +: 24];
      end
   end

   assign pix_rgb = pix_valid ? w_pix : 24'h0;
   assign pix_sof = pix_valid && (r_head_word == 17'd0) && (r_pix == 4'd0);
   assign pix_eol = pix_valid && (r_col == C_LAST_COL) && (r_pix == 4'd15);

   //---------------------------------------------------------------------------
   // Optional clear-behind-read
   //---------------------------------------------------------------------------
`ifdef SCANOUT_CLEAR_EN
   logic        r_clr_pend;
   logic [15:0] r_clr_addr;
   logic [15:0] r_inflight_addr;

   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) begin
         r_clr_pend      <= 1'b0;
         r_clr_addr      <= 16'h0;
         r_inflight_addr <= 16'h0;
      end else begin
         if (w_rd_issue) r_inflight_addr <= r_rd_addr[15:0];
         if (w_capture) begin
            r_clr_pend <= 1'b1;
            r_clr_addr <= r_inflight_addr;
         end else if (w_clr_issue) begin
            r_clr_pend <= 1'b0;
         end
      end
   end

   assign w_clr_issue     = w_run && r_clr_pend;
   assign w_clr_addr      = r_clr_addr;
   assign Color_RGB_clear = {16{CLEAR_COLOR}};
   assign depth_clear     = {16{21'h1FFFFF}};
`else
   assign w_clr_issue     = 1'b0;
   assign w_clr_addr      = 16'h0;
   // Masked to zero: the colour only matters when clearing is built in.
   assign Color_RGB_clear = {16{CLEAR_COLOR & 24'h0}};
   assign depth_clear     = 336'h0;
`endif

   //---------------------------------------------------------------------------
   // SRAM port: idle cycles repeat a read of the last address
   //---------------------------------------------------------------------------
   assign w_addr = w_clr_issue ? w_clr_addr :
                   (w_rd_issue ? r_rd_addr[15:0] : r_last_addr);

   always_ff @(posedge clk or negedge srst_n) begin
      if (!srst_n) r_last_addr <= 16'h0;
      else         r_last_addr <= w_addr;
   end

   assign address_sram_CD        = w_addr;
   assign write_enable_sram_CD   = !w_clr_issue;
   assign write_wordmask_sram_CD = w_clr_issue ? 16'h0000 : 16'hFFFF;

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_scanout.sv
`default_nettype none
//==============================================================================
// Module   : tb_frame_buffer_scanout
// Brief    : Scoreboard bench for frame_buffer_scanout with an SRAM model.
// Revision : 1.0  initial release
//==============================================================================
module tb_frame_buffer_scanout;

   localparam int          H     = 2;
   localparam int          V     = 2;
   localparam int          WORDS = H * V;
   localparam int          BEATS = WORDS * 16;
   localparam logic [23:0] CLR   = 24'h102030;

   logic         clk = 1'b0;
   logic         srst_n;
   logic         start;
   logic         busy;
   logic         done;
   logic [15:0]  address_sram_CD;
   logic         write_enable_sram_CD;
   logic [15:0]  write_wordmask_sram_CD;
   logic [383:0] Color_RGB_sram;
   logic [383:0] Color_RGB_clear;
   logic [335:0] depth_clear;
   logic         pix_valid;
   logic         pix_ready;
   logic [23:0]  pix_rgb;
   logic         pix_sof;
   logic         pix_eol;

   always #5 clk = ~clk;

   frame_buffer_scanout #(
      .H_WORDS     (H),
      .V_LINES     (V),
      .CLEAR_COLOR (CLR)
   ) dut (
      .clk                    (clk),
      .srst_n                 (srst_n),
      .start                  (start),
      .busy                   (busy),
      .done                   (done),
      .address_sram_CD        (address_sram_CD),
      .write_enable_sram_CD   (write_enable_sram_CD),
      .write_wordmask_sram_CD (write_wordmask_sram_CD),
      .Color_RGB_sram         (Color_RGB_sram),
      .Color_RGB_clear        (Color_RGB_clear),
      .depth_clear            (depth_clear),
      .pix_valid              (pix_valid),
      .pix_ready              (pix_ready),
      .pix_rgb                (pix_rgb),
      .pix_sof                (pix_sof),
      .pix_eol                (pix_eol)
   );

   typedef struct packed {
      logic [23:0] rgb;
      logic        sof;
      logic        eol;
   } beat_t;

   beat_t exp_q[$];
   int    checks   = 0;
   int    failures = 0;
   int    cyc      = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_max(input string name, input int act, input int lim);
      checks++;
      if (act < 0 || act > lim) begin
         failures++;
         $display("FAIL %s: got %0d required 0..%0d", name, act, lim);
      end
   endtask

   // Reference: beat i is word i/16, pixel i%16 of the preloaded image.
   function automatic beat_t model_beat(input int i);
      beat_t b;
      int    k;
      int    p;
      k     = i / 16;
      p     = i % 16;
      b.rgb = {8'hA0 | 8'(k), 8'h00, 8'(p)};
      b.sof = (i == 0);
      b.eol = ((k % H) == H - 1) && (p == 15);
      return b;
   endfunction

   function automatic logic [383:0] preload_word(input int k);
      logic [383:0] w;
      for (int p = 0; p < 16; p++) w[24*p +: 24] = {8'hA0 | 8'(k), 8'h00, 8'(p)};
      return w;
   endfunction

   //---------------------------------------------------------------------------
   // SRAM model: 1-cycle read latency, active-low word mask on writes.
   // The image is reloaded on every accepted start.
   //---------------------------------------------------------------------------
   logic [383:0] mem_c [WORDS];
   logic [335:0] mem_d [WORDS];
   int           sram_writes = 0;
   int           bad_addr    = 0;

   always @(posedge clk) begin
      if (address_sram_CD >= 16'(WORDS)) bad_addr++;
      if (start && !busy && !done && srst_n) begin
         for (int k = 0; k < WORDS; k++) begin
            mem_c[k] <= preload_word(k);
            mem_d[k] <= '0;
         end
      end else if (write_enable_sram_CD) begin
         Color_RGB_sram <= mem_c[address_sram_CD[1:0]];
      end else begin
         sram_writes++;
         for (int p = 0; p < 16; p++) begin
            if (!write_wordmask_sram_CD[p]) begin
               mem_c[address_sram_CD[1:0]][24*p +: 24] <= Color_RGB_clear[24*p +: 24];
               mem_d[address_sram_CD[1:0]][21*p +: 21] <= depth_clear[21*p +: 21];
            end
         end
      end
   end

   //---------------------------------------------------------------------------
   // Monitor: pops the scoreboard on every handshake
   //---------------------------------------------------------------------------
   bit    hold_chk    = 1'b0;
   beat_t held;
   bit    expect_done = 1'b0;
   int    done_count  = 0;
   int    beat_idx    = 0;
   int    start_cyc   = 0;
   int    first_lat   = -1;
   int    first_hs    = 0;
   int    last_hs     = 0;

   always @(negedge clk) begin
      beat_t e;
      if (!srst_n) begin
         exp_q.delete();
         hold_chk    = 1'b0;
         expect_done = 1'b0;
      end else begin
         if (start && !busy && !done) begin
            start_cyc = cyc;
            beat_idx  = 0;
            first_lat = -1;
         end
         if (expect_done) begin
            check("done_pulse", 384'(done), 384'd1);
            check("busy_fall", 384'(busy), 384'd0);
            expect_done = 1'b0;
            done_count++;
         end else if (done) begin
            check("spurious_done", 384'(done), 384'd0);
         end
         if (hold_chk) begin
            check("stall_valid", 384'(pix_valid), 384'd1);
            check("stall_rgb", 384'(pix_rgb), 384'(held.rgb));
            check("stall_sof", 384'(pix_sof), 384'(held.sof));
            check("stall_eol", 384'(pix_eol), 384'(held.eol));
         end
         if (pix_valid && first_lat < 0) first_lat = cyc - start_cyc;
         if (pix_valid && pix_ready) begin
            check("busy_in_beat", 384'(busy), 384'd1);
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL extra_beat: got rgb %0h expected no beat", pix_rgb);
            end else begin
               e = exp_q.pop_front();
               check("beat_rgb", 384'(pix_rgb), 384'(e.rgb));
               check("beat_sof", 384'(pix_sof), 384'(e.sof));
               check("beat_eol", 384'(pix_eol), 384'(e.eol));
               if (beat_idx == 0) first_hs = cyc;
               last_hs = cyc;
               beat_idx++;
               if (exp_q.size() == 0) expect_done = 1'b1;
            end
         end
         hold_chk = pix_valid && !pix_ready;
         held     = {pix_rgb, pix_sof, pix_eol};
      end
   end

   //---------------------------------------------------------------------------
   // Stimulus
   //---------------------------------------------------------------------------
   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},  384'(busy), 384'd0);
      check({tag, "_done"},  384'(done), 384'd0);
      check({tag, "_valid"}, 384'(pix_valid), 384'd0);
      check({tag, "_rgb"},   384'(pix_rgb), 384'd0);
      check({tag, "_sof"},   384'(pix_sof), 384'd0);
      check({tag, "_eol"},   384'(pix_eol), 384'd0);
      check({tag, "_addr"},  384'(address_sram_CD), 384'd0);
      check({tag, "_we"},    384'(write_enable_sram_CD), 384'd1);
      check({tag, "_mask"},  384'(write_wordmask_sram_CD), 384'hFFFF);
   endtask

   task automatic run_frame(input bit rand_rdy, input bit poke_start, input int reset_at,
                            input bit timing_chk);
      int d0;
      bit was_reset;
      d0        = done_count;
      was_reset = 1'b0;
      for (int i = 0; i < BEATS; i++) exp_q.push_back(model_beat(i));
      @(posedge clk); #1;
      start     = 1'b1;
      pix_ready = rand_rdy ? ($urandom_range(0, 9) >= 3) : 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if (done_count != d0) break;
         if (reset_at >= 0 && beat_idx == reset_at) begin
            srst_n = 1'b0;
            #1;
            check_reset_outputs("midreset");
            repeat (2) @(posedge clk);
            #1;
            srst_n    = 1'b1;
            was_reset = 1'b1;
            break;
         end
         pix_ready = rand_rdy ? ($urandom_range(0, 9) >= 3) : 1'b1;
         start     = (poke_start && busy && $urandom_range(0, 5) == 0);
         @(posedge clk); #1;
      end
      start = 1'b0;
      if (!was_reset) begin
         check("frame_done_count", 384'(done_count - d0), 384'd1);
         check("frame_queue_empty", 384'(exp_q.size()), 384'd0);
         if (timing_chk) begin
            check_max("first_valid_latency", first_lat, 3);
            check("stream_span", 384'(last_hs - first_hs), 384'(BEATS - 1));
         end
      end
   endtask

   task automatic check_memory();
      for (int k = 0; k < WORDS; k++) begin
`ifdef SCANOUT_CLEAR_EN
         check("mem_color_cleared", mem_c[k], {16{CLR}});
         check("mem_depth_cleared", 384'(mem_d[k]), 384'({16{21'h1FFFFF}}));
`else
         check("mem_color_kept", mem_c[k], preload_word(k));
`endif
      end
`ifdef SCANOUT_CLEAR_EN
      check("clear_color_out", Color_RGB_clear, {16{CLR}});
      check("clear_depth_out", 384'(depth_clear), 384'({16{21'h1FFFFF}}));
`else
      check("no_sram_writes", 384'(sram_writes), 384'd0);
      check("clear_color_out", Color_RGB_clear, 384'd0);
      check("clear_depth_out", 384'(depth_clear), 384'd0);
`endif
      check("addr_in_range", 384'(bad_addr), 384'd0);
   endtask

   initial begin
      srst_n    = 1'b0;
      start     = 1'b0;
      pix_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      srst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("idle_we", 384'(write_enable_sram_CD), 384'd1);

      run_frame(1'b0, 1'b0, -1, 1'b1);   // full-rate frame
      check_memory();
      run_frame(1'b1, 1'b1, -1, 1'b0);   // random backpressure, ignored starts
      check_memory();
      run_frame(1'b0, 1'b0, -1, 1'b1);   // rescan after done
      run_frame(1'b0, 1'b0, 20, 1'b0);   // reset during beat 20
      run_frame(1'b0, 1'b0, -1, 1'b1);   // full frame after reset
      check_memory();

      repeat (3) @(posedge clk);
      #1;
      check("idle_last_addr", 384'(address_sram_CD), 384'(WORDS - 1));
      check("idle_last_we", 384'(write_enable_sram_CD), 384'd1);
      check("idle_busy", 384'(busy), 384'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
